// File: rtl/audio_pkg.sv
// audio_pkg
// Shared definitions for the audio stream blocks.
//   DATA_W_DEF : default sample width (24 bits)
//   sample_t   : default-width audio sample
//   chan_w()   : width of a channel index field, never less than one bit
package audio_pkg;

  localparam int DATA_W_DEF = 24;

  typedef logic [DATA_W_DEF-1:0] sample_t;

  // A single-channel stream still carries a 1-bit tag so that port and
  // memory widths never collapse to zero.
  function automatic int chan_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/audio_fifo_mem.sv
// audio_fifo_mem
// Simple dual-port register array: one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk   : system clock
//   we    : write enable, writes wdata to waddr on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : contents of entry raddr, combinational
module audio_fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 25,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write; no reset because unread entries are never observed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/audio_stream_buffer.sv
// audio_stream_buffer
// Valid/ready first-word-fall-through buffer for audio samples with
// per-sample channel tagging, frame-last flag, fill level, almost-full
// warning and synchronous flush.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   flush           : synchronous clear of contents and channel counter
//   i_valid/o_ready : input handshake, i_data is the incoming sample
//   o_valid/i_ready : output handshake, o_data is the outgoing sample
//   o_chan          : channel index stored with o_data
//   o_last          : o_data is the last channel of its frame
//   level           : current occupancy (0..DEPTH)
//   o_almost_full   : level >= AF_LEVEL
module audio_stream_buffer
  import audio_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = 8,
  parameter int NCH      = 2,
  parameter int AF_LEVEL = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DATA_W-1:0]        i_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_W-1:0]        o_data,
  output logic [chan_w(NCH)-1:0]   o_chan,
  output logic                     o_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     o_almost_full
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int CH_W   = chan_w(NCH);
  localparam int LVL_W  = ADDR_W + 1;
  localparam int MEM_W  = DATA_W + CH_W;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CH_W-1:0]   ch_cnt;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_next;
  logic              af_q;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [MEM_W-1:0]  rd_word;

  // The extra pointer MSB distinguishes a full buffer from an empty one
  // when the address bits coincide.
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // o_ready deliberately ignores i_ready: a full buffer never passes a
  // sample through, even when a pop happens in the same cycle.
  assign o_ready = !full && !rst;
  assign o_valid = !empty;

  // Flush swallows both handshakes so nothing moves on a flush cycle.
  assign push = i_valid && o_ready && !flush;
  assign pop  = o_valid && i_ready && !flush;

  audio_fifo_mem #(
    .DEPTH  (DEPTH),
    .WIDTH  (MEM_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata ({ch_cnt, i_data}),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_word)
  );

  assign o_data = rd_word[DATA_W-1:0];
  assign o_chan = rd_word[MEM_W-1:DATA_W];
  assign o_last = (o_chan == CH_W'(NCH - 1));

  // Occupancy after this edge; also drives the registered almost-full
  // flag so that flag and level change together.
  always_comb begin
    level_next = level_q;
    if (flush) begin
      level_next = '0;
    end else if (push && !pop) begin
      level_next = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_next = level_q - LVL_W'(1);
    end
  end

  // Pointer, channel tag, level and almost-full state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ch_cnt  <= '0;
      level_q <= '0;
      af_q    <= 1'b0;
    end else begin
      level_q <= level_next;
      af_q    <= (level_next >= LVL_W'(AF_LEVEL));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ch_cnt <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          ch_cnt <= (ch_cnt == CH_W'(NCH - 1)) ? '0 : ch_cnt + CH_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  assign level         = level_q;
  assign o_almost_full = af_q;

endmodule

// File: doc/audio_stream_buffer.md
Name: audio_stream_buffer

Overview:
Parametrised valid/ready stream buffer for the audio chain. It is the next generation of the single-sample dfb pass stage: configurable sample width, depth and channel count. It adds per-sample channel tagging, a frame-last flag, fill-level reporting, almost-full back-pressure warning and synchronous flush. It sits between audio_bus producers and consumers to absorb burstiness, for example between the I2S/codec side and the DSP chain.

Parameters:
DATA_W, 24, sample width in bits
DEPTH, 8, number of entries; power of two, >= 2
NCH, 2, channels per frame (interleaved samples); >= 1
AF_LEVEL, 6, o_almost_full asserts when level >= AF_LEVEL; 1..DEPTH

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of contents and channel counter
i_valid  in  1  input sample valid
o_ready  out  1  buffer can accept a sample
i_data  in  DATA_W  input sample
o_valid  out  1  output sample valid
i_ready  in  1  downstream accepts
o_data  out  DATA_W  output sample
o_chan  out  $clog2(NCH) (min 1)  channel index of o_data
o_last  out  1  o_chan == NCH-1 (last sample of frame)
level  out  $clog2(DEPTH)+1  current occupancy
o_almost_full  out  1  level >= AF_LEVEL

Behaviour:
- Only one clock; all state is on posedge clk with async clear on rst.
- Reset values: wr_ptr=0, rd_ptr=0, channel counter=0, level=0, o_valid=0, o_almost_full=0. o_ready=0 while rst is high and 1 after release. Memory contents are don't-care.
- Push = i_valid & o_ready. Pop = o_valid & i_ready. Transfers occur only on those cycles. i_data is ignored otherwise.
- Pointers are ADDR_W+1 bits wide, with ADDR_W = log2(DEPTH). full = (MSBs differ, low bits equal). empty = (pointers equal). Wrap-around is natural modulo 2*DEPTH.
- o_ready = !full & !rst. It does not depend on i_ready: no pass-through when full, even if a pop occurs the same cycle.
- Output is first-word-fall-through. o_valid = !empty, and o_data/o_chan come from the entry at rd_ptr.
- Latency: a sample pushed in cycle N appears on o_valid in cycle N+1 at the earliest. There is no same-cycle bypass when empty.
- Output stability: while o_valid=1 and i_ready=0, o_data/o_chan/o_last hold stable.
- Channel tag:
  - The write-side counter is stored alongside each sample.
  - It increments on each push and wraps from NCH-1 to 0.
  - If NCH=1, the tag is always 0 and o_last is always 1.
- Level arithmetic (applied only when flush=0):
  - push & !pop: +1
  - pop & !push: -1
  - both or neither: unchanged
  - Level never exceeds DEPTH or goes below 0 by construction.
- Simultaneous push and pop when neither full nor empty: both happen, and level is unchanged.
- Simultaneous push and pop when empty: the push only is stored (o_valid=0, so no pop).
- Simultaneous push and pop when full: the pop only happens (o_ready=0).
- Flush:
  - Takes priority over push/pop in the same cycle. Any sample presented that cycle is dropped, even if o_ready=1.
  - Next cycle: pointers=0, level=0, channel counter=0, o_valid=0.
  - o_ready stays 1 through flush.
- Reset mid-stream discards all contents and immediately forces o_valid=0 and o_ready=0 (async).
- o_almost_full is registered from the next-state level, so it is coherent with level in the same cycle.

Decomposition:
- audio_pkg (shared):
  - DATA_W default constant (24)
  - sample_t typedef (logic [23:0])
  - a helper constant/function for clog2-min-1 channel width
- Natural sub-module: audio_fifo_mem, a simple dual-port register array DEPTH x (DATA_W + chan width) with a synchronous write and an asynchronous read at rd address.
- Pointer, level and channel logic stays in audio_stream_buffer.

Test Plan (DATA_W=24, DEPTH=8, NCH=2, AF_LEVEL=6):
- Reset then idle -> o_valid=0, o_ready=1, level=0. Assert rst mid-burst -> o_valid=0, o_ready=0 asynchronously; after release, empty.
- Push 0x000001..0x000004 with i_ready=0 -> level 1,2,3,4. Then i_ready=1 -> outputs in order with o_chan 0,1,0,1 and o_last 0,1,0,1; first sample visible one cycle after its push.
- Push 8 samples with i_ready=0 -> o_ready=0 after the 8th push, level=8, o_almost_full=1 from level 6. A 9th i_valid is not accepted. A single pop -> o_ready=1 next cycle, level=7.
- Continuous i_valid=1/i_ready=1 for 40 cycles at level 3 -> level constant at 3, data in order, pointer wrap correct, channel tags alternate continuously.
- Random i_valid/i_ready (50% each), 2000 samples versus a scoreboard queue -> no loss, duplication or reorder; o_data stable while stalled.
- At level 5 with channel counter=1, assert flush with i_valid=1 and i_ready=1 -> next cycle level=0, o_valid=0. The next push is tagged o_chan=0, and the flushed-cycle sample never appears.
